// File: rtl/fft_c0.sv
// First-stage radix-2 DIT butterfly (twiddle W^0): registered y0 = a+b, y1 = a-b per component.
// Define FFT_C0_SATURATE_EN to clamp each component instead of wrapping modulo 2^DW.
module fft_c0 #(
   parameter int unsigned DW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [2*DW-1:0] a,
   input  logic [2*DW-1:0] b,
   output logic [2*DW-1:0] y0,
   output logic [2*DW-1:0] y1,
   output logic            out_valid
);

   logic [DW-1:0] a_re, a_im, b_re, b_im;
   logic [2*DW-1:0] sum_n, dif_n;

   assign a_re = a[DW-1:0];
   assign a_im = a[2*DW-1:DW];
   assign b_re = b[DW-1:0];
   assign b_im = b[2*DW-1:DW];

`ifdef FFT_C0_SATURATE_EN
   // One extra sign bit exposes overflow: top two bits disagree means out of range.
   function automatic logic [DW-1:0] clamp(input logic [DW:0] s);
      logic [DW-1:0] r;
      if (s[DW] != s[DW-1])
         r = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
         r = s[DW-1:0];
      return r;
   endfunction

   logic [DW:0] re_sum, im_sum, re_dif, im_dif;

   always_comb begin
      re_sum = {a_re[DW-1], a_re} + {b_re[DW-1], b_re};
      im_sum = {a_im[DW-1], a_im} + {b_im[DW-1], b_im};
      re_dif = {a_re[DW-1], a_re} - {b_re[DW-1], b_re};
      im_dif = {a_im[DW-1], a_im} - {b_im[DW-1], b_im};
      sum_n  = {clamp(im_sum), clamp(re_sum)};
      dif_n  = {clamp(im_dif), clamp(re_dif)};
   end
`else
   logic [DW-1:0] re_sum, im_sum, re_dif, im_dif;

   // Components are computed separately so no carry crosses the re/im boundary.
   always_comb begin
      re_sum = a_re + b_re;
      im_sum = a_im + b_im;
      re_dif = a_re - b_re;
      im_dif = a_im - b_im;
      sum_n  = {im_sum, re_sum};
      dif_n  = {im_dif, re_dif};
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y0        <= '0;
         y1        <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            y0 <= sum_n;
            y1 <= dif_n;
         end
      end
   end

endmodule

// File: tb/tb_fft_c0.sv
// Self-checking bench for fft_c0: directed cases plus randomized traffic against a behavioural model.
module tb_fft_c0;

   localparam int unsigned DW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic [2*DW-1:0] a, b;
   logic [2*DW-1:0] y0, y1;
   logic            out_valid;

   int passed = 0;
   int total  = 0;

   logic [4*DW:0] obs, exp_v;

   fft_c0 #(.DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a), .b(b), .y0(y0), .y1(y1), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // One signed component result from integer arithmetic, then wrap or clamp.
   function automatic logic [DW-1:0] comp(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                          input bit sub);
      int xi, yi, r;
      xi = int'($signed(x));
      yi = int'($signed(y));
      r  = sub ? xi - yi : xi + yi;
`ifdef FFT_C0_SATURATE_EN
      if (r > (2 ** (DW - 1)) - 1) r = (2 ** (DW - 1)) - 1;
      if (r < -(2 ** (DW - 1)))    r = -(2 ** (DW - 1));
`endif
      return DW'(r);
   endfunction

   // Returns {y1, y0} for a complex pair.
   function automatic logic [4*DW-1:0] butterfly(input logic [2*DW-1:0] x, input logic [2*DW-1:0] y);
      logic [2*DW-1:0] s, d;
      for (int k = 0; k < 2; k++) begin
         s[k*DW +: DW] = comp(x[k*DW +: DW], y[k*DW +: DW], 1'b0);
         d[k*DW +: DW] = comp(x[k*DW +: DW], y[k*DW +: DW], 1'b1);
      end
      return {d, s};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h5678;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs = {out_valid, y1, y0};
         exp_v = '0;
         total++;
         if (obs !== exp_v) $display("FAIL reset[%0d]: got %h expected %h", i, obs, exp_v);
         else passed++;
      end
      rst_n = 1'b1; in_valid = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      logic [2*DW-1:0] ta [5];
      logic [2*DW-1:0] tb_ [5];
      logic [4*DW-1:0] te [5];
      ta[0] = 16'h0005; tb_[0] = 16'h0003; te[0] = {16'h0002, 16'h0008};
      ta[1] = 16'h0003; tb_[1] = 16'h0005; te[1] = {16'h00FE, 16'h0008};
      ta[2] = 16'h1000; tb_[2] = 16'h0200; te[2] = {16'h0E00, 16'h1200};
      ta[3] = 16'h00FF; tb_[3] = 16'h0001; te[3] = {16'h00FE, 16'h0000};
      ta[4] = 16'h7F7F; tb_[4] = 16'h0101;
`ifdef FFT_C0_SATURATE_EN
      te[4] = {16'h7E7E, 16'h7F7F};
`else
      te[4] = {16'h7E7E, 16'h8080};
`endif
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; a = ta[i]; b = tb_[i];
         tick();
         obs = {out_valid, y1, y0};
         exp_v = {1'b1, te[i]};
         total++;
         if (obs !== exp_v) $display("FAIL directed[%0d]: got %h expected %h", i, obs, exp_v);
         else passed++;
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_overflow_neg();
      in_valid = 1'b1; a = 16'h8080; b = 16'h0101;
      tick();
      obs = {out_valid, y1, y0};
`ifdef FFT_C0_SATURATE_EN
      exp_v = {1'b1, 16'h8080, 16'h8181};
`else
      exp_v = {1'b1, 16'h7F7F, 16'h8181};
`endif
      total++;
      if (obs !== exp_v) $display("FAIL underflow: got %h expected %h", obs, exp_v);
      else passed++;
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; a = 16'(i); b = 16'h0001;
         tick();
         obs = {out_valid, y1, y0};
         exp_v = {1'b1, 16'(i - 1), 16'(i + 1)};
         total++;
         if (obs !== exp_v) $display("FAIL stream[%0d]: got %h expected %h", i, obs, exp_v);
         else passed++;
      end
      in_valid = 1'b0; a = 16'hAAAA; b = 16'h5555;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs = {out_valid, y1, y0};
         exp_v = {1'b0, 16'h0003, 16'h0005};
         total++;
         if (obs !== exp_v) $display("FAIL hold[%0d]: got %h expected %h", i, obs, exp_v);
         else passed++;
      end
   endtask

   task automatic test_mid_reset();
      in_valid = 1'b1; a = 16'h0002; b = 16'h0001;
      tick();
      rst_n = 1'b0; a = 16'h0009; b = 16'h0001;
      tick();
      obs = {out_valid, y1, y0};
      exp_v = '0;
      total++;
      if (obs !== exp_v) $display("FAIL mid_reset: got %h expected %h", obs, exp_v);
      else passed++;
      rst_n = 1'b1; in_valid = 1'b0;
      tick();
      obs = {out_valid, y1, y0};
      total++;
      if (obs !== exp_v) $display("FAIL after_reset: got %h expected %h", obs, exp_v);
      else passed++;
   endtask

   task automatic test_random();
      logic [4*DW-1:0] held;
      logic            v;
      held = {y1, y0};
      for (int i = 0; i < 300; i++) begin
         v = 1'($urandom_range(0, 3) != 0);
         in_valid = v; a = 16'($urandom); b = 16'($urandom);
         if (v) held = butterfly(a, b);
         tick();
         obs = {out_valid, y1, y0};
         exp_v = {v, held};
         total++;
         if (obs !== exp_v) $display("FAIL random[%0d]: a=%h b=%h got %h expected %h", i, a, b, obs, exp_v);
         else passed++;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
      #1;
      test_reset();
      test_directed();
      test_overflow_neg();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
